// File: rtl/rv_pkg.sv
// Shared definitions for the RV32I pipeline front end.
package rv_pkg;

  // addi x0, x0, 0 -- the canonical bubble word
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;

  // Default PC loaded on reset
  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;

  // FETCH: normal fetching; DRAIN: a wrong-path miss is still outstanding
  typedef enum logic {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } fetch_state_t;

  // Force a redirect target onto a word boundary
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register. clr inserts a bubble (instruction and valid only,
// the PC fields keep their value), stall holds, en loads a fetched word.
module if_id_reg
  import rv_pkg::*;
#(
  parameter logic [31:0] NOP = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        clr,
  input  logic        stall,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc_in,
  input  logic [31:0] pc_plus4_in,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc_plus4_d,
  output logic        valid_d
);

  // Priority: reset, then clr (bubble), then stall (hold), then load
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instr_d    <= NOP;
      pc_d       <= 32'h0;
      pc_plus4_d <= 32'h0;
      valid_d    <= 1'b0;
    end else if (clr) begin
      instr_d <= NOP;
      valid_d <= 1'b0;
    end else if (stall) begin
      instr_d    <= instr_d;
      pc_d       <= pc_d;
      pc_plus4_d <= pc_plus4_d;
      valid_d    <= valid_d;
    end else if (en) begin
      instr_d    <= instr_in;
      pc_d       <= pc_in;
      pc_plus4_d <= pc_plus4_in;
      valid_d    <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, fetches words from the I-cache and loads IF/ID.
//
// I-cache handshake: ic_req is high whenever out of reset. A cycle with
// ic_req=1 and ic_valid=0 is a miss in progress, and ic_addr is held
// constant until the cycle in which ic_valid=1 returns the word for it.
// A redirect that arrives while a miss is outstanding cannot retarget the
// cache, so the FSM enters DRAIN, keeps the old address until the miss
// completes, throws that data away and then jumps to the newest target.
module fetch_stage
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         stall_d,
  input  logic         redirect_e,
  input  logic [31:0]  redirect_pc_e,
  output logic         ic_req,
  output logic [31:0]  ic_addr,
  input  logic         ic_valid,
  input  logic [31:0]  ic_rdata,
  output logic [31:0]  instr_d,
  output logic [31:0]  pc_d,
  output logic [31:0]  pc_plus4_d,
  output logic         valid_d,
  output fetch_state_t state_dbg
);

  fetch_state_t state;
  logic [31:0]  pc_f;
  logic [31:0]  pend_pc;
  logic [31:0]  pc_f_plus4;
  logic [31:0]  redir_aligned;
  logic         ifid_en;
  logic         ifid_clr;
  logic         ifid_stall;

  assign pc_f_plus4    = pc_f + 32'd4;
  assign redir_aligned = word_align(redirect_pc_e);

  assign ic_req    = rst_n;
  assign ic_addr   = pc_f;
  assign state_dbg = state;

  // IF/ID control: flush on redirect or miss bubble, hold on stall, load on hit
  always_comb begin
    ifid_en    = 1'b0;
    ifid_clr   = 1'b0;
    ifid_stall = stall_d;
    if (state == FETCH) begin
      ifid_clr = redirect_e | (!stall_d & !ic_valid);
      ifid_en  = ic_valid;
    end else begin
      ifid_clr = !stall_d;
    end
  end

  // Fetch FSM and PC: redirect beats stall beats hit; DRAIN waits out a miss
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= FETCH;
      pc_f    <= RESET_PC;
      pend_pc <= 32'h0;
    end else begin
      case (state)
        FETCH: begin
          if (redirect_e) begin
            if (ic_valid) begin
              pc_f <= redir_aligned;
            end else begin
              pend_pc <= redir_aligned;
              state   <= DRAIN;
            end
          end else if (!stall_d && ic_valid) begin
            pc_f <= pc_f_plus4;
          end
        end
        DRAIN: begin
          if (redirect_e) begin
            pend_pc <= redir_aligned;
          end
          if (ic_valid) begin
            pc_f  <= redirect_e ? redir_aligned : pend_pc;
            state <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

  if_id_reg #(
    .NOP (NOP_INSTR)
  ) u_if_id (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (ifid_en),
    .clr         (ifid_clr),
    .stall       (ifid_stall),
    .instr_in    (ic_rdata),
    .pc_in       (pc_f),
    .pc_plus4_in (pc_f_plus4),
    .instr_d     (instr_d),
    .pc_d        (pc_d),
    .pc_plus4_d  (pc_plus4_d),
    .valid_d     (valid_d)
  );

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- IF stage plus IF/ID pipeline register for the pipelined RV32I core with instruction cache.
- Holds the PC and issues word fetches to the I-cache over a request/valid handshake, with miss waits.
- Absorbs decode stalls and EX-stage redirects, including a redirect that arrives during an outstanding miss.
- Its outputs feed decode: instr_d[31:7] goes to the immediate extender and instr_d[6:0] to the control unit.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded at reset.
- NOP_INSTR, 32'h0000_0013, instruction word (addi x0,x0,0) placed in IF/ID for a bubble.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- stall_d  in  1  hazard unit request to hold IF/ID and PC.
- redirect_e  in  1  taken branch or jump resolved in EX.
- redirect_pc_e  in  32  redirect target.
- ic_req  out  1  fetch request to I-cache.
- ic_addr  out  32  fetch address; bits [1:0] are always 0.
- ic_valid  in  1  I-cache returns data for ic_addr this cycle (hit same cycle, miss later).
- ic_rdata  in  32  instruction word, qualified by ic_valid.
- instr_d  out  32  IF/ID instruction.
- pc_d  out  32  IF/ID PC.
- pc_plus4_d  out  32  IF/ID PC+4.
- valid_d  out  1  IF/ID holds a real instruction.

Behaviour:
- Reset (rst_n=0 at clk edge):
  - pc_f=RESET_PC, state=FETCH, pend_pc=0.
  - instr_d=NOP_INSTR, pc_d=0, pc_plus4_d=0, valid_d=0.
  - ic_req=0 while rst_n=0.
  - Reset mid-miss abandons the miss; the cache is reset by the same rst_n.
- Handshake:
  - ic_req=1 in both states when out of reset; ic_addr is driven from the state register.
  - Any cycle with ic_req=1 and ic_valid=0 means a miss is outstanding; ic_addr must stay unchanged until ic_valid=1.
- ic_addr:
  - FETCH: pc_f.
  - DRAIN: pc_f, the old address held until the miss completes.
- Redirect address: redirect_pc_e[1:0] is forced to 00 when captured.
- PC arithmetic: mod 2^32, so 32'hFFFF_FFFC + 4 = 0.
- State FETCH, per-cycle priority:
  - redirect_e=1:
    - IF/ID flushes: instr_d=NOP_INSTR, valid_d=0, pc_d and pc_plus4_d unchanged. Flush beats stall_d.
    - If ic_valid=1: data is discarded, pc_f<=redirect_pc_e, stay in FETCH.
    - If ic_valid=0: pend_pc<=redirect_pc_e, go to DRAIN.
  - else stall_d=1: IF/ID and pc_f hold; any ic_valid data is discarded and refetched next cycle.
  - else ic_valid=1: IF/ID<={ic_rdata, pc_f, pc_f+4, 1}, pc_f<=pc_f+4.
  - else (miss waiting): IF/ID<=bubble (NOP_INSTR, valid 0), pc_f holds.
- State DRAIN (wrong-path miss outstanding):
  - IF/ID becomes a bubble each cycle unless stall_d=1, in which case it holds.
  - redirect_e=1 overwrites pend_pc; the newest redirect wins.
  - On ic_valid=1:
    - data is discarded.
    - pc_f<=pend_pc, or redirect_pc_e if redirect_e=1 in the same cycle.
    - go to FETCH.
  - Never issues a new address until the drain completes.
- Latency:
  - Hit: instruction visible in IF/ID the cycle after the request; one instruction per cycle sustained.
  - Redirect on a hit: the target is requested the next cycle; one bubble in ID.
- valid_d=0 implies instr_d=NOP_INSTR at all times.

Decomposition:
- Shared package rv_pkg holds:
  - NOP_INSTR constant.
  - fetch_state_t enum {FETCH, DRAIN}.
  - RESET_PC default.
- One sub-module if_id_reg: register with inputs en (load), clr (bubble) and stall.
  - clr has priority over stall.
  - Reset and clr both load NOP_INSTR and valid 0.
- The FSM and PC logic stay in fetch_stage.

Test Plan:
- Reset then hits: rst_n low 2 cycles, then high; ic_valid=1 always, rdata=addr^32'hA5A5_0000.
  - Required: ic_addr goes 0,4,8,...
  - Required: valid_d=1 from the 2nd cycle with pc_d=0, instr_d=32'hA5A5_0000, pc_plus4_d=4.
- Miss: ic_addr=0x10, ic_valid low 3 cycles then high with rdata 32'h0010_0093.
  - Required: ic_addr stays 0x10 for 4 cycles, valid_d=0 for 3 cycles.
  - Required: then instr_d=32'h0010_0093, pc_d=0x10.
- Stall: stall_d=1 for 2 cycles while pc_d=0x8.
  - Required: pc_d, instr_d and ic_addr hold (ic_addr=0xC).
  - Required: after release, pc_d=0xC next cycle with no instruction lost.
- Redirect on hit with simultaneous stall_d=1: redirect_pc_e=0x103 at pc_f=0x20.
  - Required: next cycle valid_d=0, instr_d=NOP_INSTR, ic_addr=0x100.
- Redirect during miss: miss at 0x40, redirect to 0x200, then a second redirect to 0x300 before ic_valid.
  - Required: ic_addr stays 0x40 until ic_valid.
  - Required: the data for 0x40 never reaches IF/ID; next ic_addr=0x300.
- Wrap and mid-miss reset: pc at 0xFFFF_FFFC on a hit gives next ic_addr=0. rst_n low during a miss gives pc=RESET_PC, state=FETCH and valid_d=0 the next cycle.
